action_scheduler: RTL and testbench

Sequences player input into the pet game-state FSM. It turns raw USB keycodes into single press events and buffers them in a small queue. It offers the queued actions to the game FSM one at a time over a valid/ack handshake, and it generates the frame-divided animation step tick that paces the FSM's idle, feed and pet sprite sequences.

---
 rtl/game_pkg.sv | 21 ++
 rtl/action_fifo.sv | 69 ++++++
 rtl/action_scheduler.sv | 150 +++++++++++++++
 tb/tb_action_scheduler.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the pet game.
// - action_t: the action codes passed from the scheduler to the game-state FSM.
// - Keycode constants: the USB keycodes the scheduler and the FSM agree on.
// - QCOUNT_W: width of the queue-occupancy bus.
package game_pkg;

  typedef enum logic [1:0] {
    ACT_NONE    = 2'd0,
    ACT_FEED    = 2'd1,
    ACT_PET     = 2'd2,
    ACT_RESTART = 2'd3
  } action_t;

  localparam logic [7:0] KEYCODE_NONE    = 8'h00;
  localparam logic [7:0] KEYCODE_FEED    = 8'h14;  // Q
  localparam logic [7:0] KEYCODE_PET     = 8'h1a;  // W
  localparam logic [7:0] KEYCODE_RESTART = 8'h16;  // S

  localparam int QCOUNT_W = 4;

endpackage

// File: rtl/action_fifo.sv
// action_fifo: synchronous QDEPTH-entry FIFO of action_t.
// Ports:
//   frame_clk, Reset : clock; asynchronous active-high reset (clears pointers/count)
//   push, din        : write din at the tail
//   pop              : remove the head entry
//   flush            : empty the queue; a same-cycle push lands as the only entry
//   head             : entry at the head (valid when !empty)
//   count            : occupancy 0..QDEPTH
//   full, empty      : occupancy flags
// Priority: flush over pop; a pop makes room for a push even when full.
module action_fifo
  import game_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                push,
  input  action_t             din,
  input  logic                pop,
  input  logic                flush,
  output action_t             head,
  output logic [QCOUNT_W-1:0] count,
  output logic                full,
  output logic                empty
);

  localparam int                PTR_W   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [QCOUNT_W-1:0] DEPTH_C = QCOUNT_W'(QDEPTH);

  action_t          mem [QDEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? PTR_W'(1) : '0;
      count  <= push ? QCOUNT_W'(1) : '0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      count <= count + QCOUNT_W'(do_push) - QCOUNT_W'(do_pop);
    end
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge frame_clk) begin
    if (flush) begin
      if (push) mem[0] <= din;
    end else if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/action_scheduler.sv
// action_scheduler: turns raw USB keycodes into single press events, queues
// them, offers them one at a time to the game FSM over valid/ack, and
// generates the frame-divided animation step tick.
// Ports:
//   frame_clk, Reset : clock; asynchronous active-high reset
//   key              : current keycode (8'h00 = no key)
//   busy             : game FSM mid-animation; no new offer while high
//   act_ack          : FSM accepts the offered action this cycle
//   act_valid        : an action is offered
//   act_code         : offered action_t (ACT_NONE when act_valid is 0)
//   step             : one-cycle animation tick every FRAMES_PER_STEP cycles
//   qcount           : queue occupancy 0..QDEPTH
//   dropped          : one-cycle pulse when a press is lost to a full queue
module action_scheduler
  import game_pkg::*;
#(
  parameter int         FRAMES_PER_STEP = 15,
  parameter int         QDEPTH          = 4,
  parameter logic [7:0] KEY_FEED        = KEYCODE_FEED,
  parameter logic [7:0] KEY_PET         = KEYCODE_PET,
  parameter logic [7:0] KEY_RESTART     = KEYCODE_RESTART
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic [7:0]          key,
  input  logic                busy,
  input  logic                act_ack,
  output logic                act_valid,
  output logic [1:0]          act_code,
  output logic                step,
  output logic [QCOUNT_W-1:0] qcount,
  output logic                dropped
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  localparam logic [7:0] STEP_LAST = 8'(FRAMES_PER_STEP - 1);

  logic [7:0]  key_prev;
  logic        key_change;
  logic        feed_press;
  logic        pet_press;
  logic        restart_press;
  logic        push_req;
  action_t     push_code;
  logic        handshake;
  logic [0:0]  state;
  logic [7:0]  div_cnt;

  action_t     fifo_head;
  logic        fifo_full;
  logic        fifo_empty;

  // Press detect: a press is the first cycle a known keycode appears.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) key_prev <= '0;
    else       key_prev <= key;
  end

  assign key_change    = (key != key_prev);
  assign feed_press    = key_change && (key == KEY_FEED);
  assign pet_press     = key_change && (key == KEY_PET);
  assign restart_press = key_change && (key == KEY_RESTART);
  assign push_req      = feed_press || pet_press || restart_press;
  assign handshake     = act_valid && act_ack;

  always_comb begin
    push_code = ACT_PET;
    if (restart_press)   push_code = ACT_RESTART;
    else if (feed_press) push_code = ACT_FEED;
  end

  // Restart drives flush; the FIFO then stores the restart as its only entry,
  // which also covers a same-cycle ack (pop is subsumed by the flush).
  action_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .push      (push_req),
    .din       (push_code),
    .pop       (handshake),
    .flush     (restart_press),
    .head      (fifo_head),
    .count     (qcount),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) dropped <= 1'b0;
    else       dropped <= (feed_press || pet_press) && fifo_full && !handshake;
  end

  // Issue FSM: act_code is captured on entry to OFFER and held, so it stays
  // stable for the whole offer even though busy may rise meanwhile.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      act_valid <= 1'b0;
      act_code  <= ACT_NONE;
    end else if (restart_press) begin
      state     <= ST_IDLE;
      act_valid <= 1'b0;
      act_code  <= ACT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty && !busy) begin
            state     <= ST_OFFER;
            act_valid <= 1'b1;
            act_code  <= fifo_head;
          end
        end
        ST_OFFER: begin
          if (act_ack) begin
            state     <= ST_IDLE;
            act_valid <= 1'b0;
            act_code  <= ACT_NONE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          act_valid <= 1'b0;
          act_code  <= ACT_NONE;
        end
      endcase
    end
  end

  // Step divider: an accepted action restarts the count so the sprite
  // sequence starts on a full step.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      div_cnt <= '0;
      step    <= 1'b0;
    end else if (handshake) begin
      div_cnt <= '0;
      step    <= 1'b0;
    end else if (div_cnt == STEP_LAST) begin
      div_cnt <= '0;
      step    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 8'd1;
      step    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_action_scheduler.sv
// Directed testbench for action_scheduler with an offer scoreboard: the
// stimulus pushes the action it expects to be offered next; a monitor pops and
// compares whenever a new offer appears on act_valid.
module tb_action_scheduler;

  localparam logic [7:0] KQ = 8'h14;
  localparam logic [7:0] KW = 8'h1a;
  localparam logic [7:0] KS = 8'h16;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic [7:0] key       = 8'h00;
  logic       busy      = 1'b0;
  logic       act_ack   = 1'b0;
  logic       act_valid;
  logic [1:0] act_code;
  logic       step;
  logic [3:0] qcount;
  logic       dropped;

  int total = 0;
  int bad   = 0;

  logic [1:0] exp_q[$];
  logic       prev_v = 1'b0;

  action_scheduler #(
    .FRAMES_PER_STEP (15),
    .QDEPTH          (4)
  ) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .key       (key),
    .busy      (busy),
    .act_ack   (act_ack),
    .act_valid (act_valid),
    .act_code  (act_code),
    .step      (step),
    .qcount    (qcount),
    .dropped   (dropped)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge frame_clk);
    #1;
  endtask

  // Waits (bounded) for an offer, then moves past the monitor's sample point.
  task automatic wait_valid(input string name);
    int i;
    for (i = 0; i < 20; i++) begin
      if (act_valid) break;
      cyc(1);
    end
    total++;
    if (!act_valid) begin
      bad++;
      $display("FAIL %s: no offer within 20 cycles", name);
    end
    @(negedge frame_clk);
    #1;
  endtask

  task automatic ack_offer(input string name);
    wait_valid(name);
    act_ack = 1'b1;
    cyc(1);
    act_ack = 1'b0;
  endtask

  task automatic press(input logic [7:0] k);
    key = k;
    cyc(1);
    key = 8'h00;
    cyc(1);
  endtask

  // Offer monitor / scoreboard.
  always @(negedge frame_clk) begin
    if (act_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL offer_unexpected: got code %0d, none expected at %0t", act_code, $time);
      end else begin
        chk("offer_code", 32'(act_code), 32'(exp_q.pop_front()));
      end
    end
    if (!act_valid) chk("idle_code", 32'(act_code), 32'd0);
    prev_v = act_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc(3);
    chk("rst_valid",   32'(act_valid), 32'd0);
    chk("rst_code",    32'(act_code),  32'd0);
    chk("rst_step",    32'(step),      32'd0);
    chk("rst_qcount",  32'(qcount),    32'd0);
    chk("rst_dropped", 32'(dropped),   32'd0);
    Reset = 1'b0;
    cyc(2);

    // Held key: one press, offer two edges after it
    key = KQ;
    exp_q.push_back(2'd1);
    cyc(1);
    chk("held_q1",     32'(qcount),    32'd1);
    chk("held_v_e1",   32'(act_valid), 32'd0);
    cyc(1);
    chk("held_v_e2",   32'(act_valid), 32'd1);
    chk("held_code",   32'(act_code),  32'd1);
    act_ack = 1'b1;
    cyc(1);
    act_ack = 1'b0;
    chk("held_v_ack",  32'(act_valid), 32'd0);
    chk("held_q_ack",  32'(qcount),    32'd0);
    cyc(7);
    key = 8'h00;
    cyc(3);
    chk("held_v_end",  32'(act_valid), 32'd0);
    chk("held_q_end",  32'(qcount),    32'd0);

    // Overflow: five presses into a 4-deep queue while busy
    busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      key = (i % 2 == 0) ? KQ : KW;
      if (i < 4) exp_q.push_back((i % 2 == 0) ? 2'd1 : 2'd2);
      cyc(1);
      chk("ovf_dropped", 32'(dropped), (i == 4) ? 32'd1 : 32'd0);
      key = 8'h00;
      cyc(1);
      chk("ovf_drop_clr", 32'(dropped), 32'd0);
    end
    chk("ovf_qcount", 32'(qcount), 32'd4);

    // Full plus pop: press W with the ack of the head
    busy = 1'b0;
    wait_valid("full_pop_offer");
    key = KW;
    act_ack = 1'b1;
    exp_q.push_back(2'd2);
    cyc(1);
    key = 8'h00;
    act_ack = 1'b0;
    chk("fp_qcount",  32'(qcount),  32'd4);
    chk("fp_dropped", 32'(dropped), 32'd0);
    for (int i = 0; i < 4; i++) ack_offer("fp_drain");
    chk("fp_q_drained", 32'(qcount), 32'd0);

    // Restart cancels the offer and flushes the queue
    busy = 1'b1;
    press(KQ); press(KW); press(KQ);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd1);
    busy = 1'b0;
    wait_valid("rs_offer");
    chk("rs_q3",    32'(qcount),   32'd3);
    chk("rs_code",  32'(act_code), 32'd1);
    key = KS;
    exp_q.delete();
    exp_q.push_back(2'd3);
    cyc(1);
    key = 8'h00;
    chk("rs_valid", 32'(act_valid), 32'd0);
    chk("rs_q1",    32'(qcount),    32'd1);
    ack_offer("rs_restart_offer");
    chk("rs_q0",    32'(qcount),    32'd0);

    // Step alignment after an accepted action
    key = KQ;
    exp_q.push_back(2'd1);
    cyc(1);
    key = 8'h00;
    wait_valid("st_offer");
    act_ack = 1'b1;
    cyc(1);
    act_ack = 1'b0;
    chk("step_k0", 32'(step), 32'd0);
    for (int k = 1; k <= 30; k++) begin
      cyc(1);
      chk("step_k", 32'(step), (k == 15 || k == 30) ? 32'd1 : 32'd0);
    end

    // Reset mid-offer
    busy = 1'b1;
    press(KQ); press(KW); press(KQ);
    exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd1);
    busy = 1'b0;
    wait_valid("rm_offer");
    chk("rm_q3", 32'(qcount), 32'd3);
    Reset = 1'b1;
    exp_q.delete();
    #2;
    chk("rm_valid",   32'(act_valid), 32'd0);
    chk("rm_code",    32'(act_code),  32'd0);
    chk("rm_step",    32'(step),      32'd0);
    chk("rm_qcount",  32'(qcount),    32'd0);
    chk("rm_dropped", 32'(dropped),   32'd0);
    cyc(2);
    Reset = 1'b0;
    cyc(6);
    chk("rm_post_valid", 32'(act_valid), 32'd0);
    chk("rm_post_q",     32'(qcount),    32'd0);
    key = KW;
    exp_q.push_back(2'd2);
    cyc(1);
    key = 8'h00;
    ack_offer("rm_new_offer");

    cyc(3);
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
